// File: rtl/apb_fsm_controller.sv
// APB master sequencer: runs one SETUP/ACCESS sequence per qualified AHB transfer.
// Optional macro PREADY_EN adds the PREADY input and APB wait states in ACCESS.
module apb_fsm_controller #(
   parameter int DATA_WIDTH   = 32,
   parameter int REGION_SHIFT = 26
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  valid,
   input  logic [1:0]            HTRANS,
   input  logic [31:0]           HADDR,
   input  logic                  HWRITE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
`ifdef PREADY_EN
   input  logic                  PREADY,
`endif
   output logic                  HREADYout,
   output logic [31:0]           PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PWRITE,
   output logic [2:0]            PSELx,
   output logic                  PENABLE
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WWAIT  = 2'd1,
      SETUP  = 2'd2,
      ACCESS = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [31:0]             addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    write_q;
   logic [2:0]              sel_q, sel_d;
   logic [2:0]              psel_q;
   logic                    penable_q;
   logic                    hready_q;
   logic                    start_s;
   logic                    load_s;
   logic                    done_s;
   logic                    unused_s;

   function automatic logic [2:0] region_sel(input logic [1:0] region);
      case (region)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         2'd2:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
   assign start_s  = valid & HTRANS[1];
   assign unused_s = HTRANS[0];

`ifdef PREADY_EN
   assign done_s    = PREADY;
   assign HREADYout = (state_q == ACCESS) ? PREADY : hready_q;
`else
   assign done_s    = 1'b1;
   assign HREADYout = hready_q;
`endif

   assign PADDR   = addr_q;
   assign PWDATA  = wdata_q;
   assign PWRITE  = write_q;
   assign PSELx   = psel_q;
   assign PENABLE = penable_q;

   // Next-state and latch-enable decode.
   always_comb begin
      state_d = state_q;
      load_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_s) begin
               load_s  = 1'b1;
               state_d = HWRITE ? WWAIT : SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         WWAIT:  state_d = SETUP;
         SETUP:  state_d = ACCESS;
         ACCESS: begin
            if (!done_s) begin
               state_d = ACCESS;
            end else if (start_s) begin
               load_s  = 1'b1;
               state_d = HWRITE ? WWAIT : SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      sel_d = load_s ? region_sel(HADDR[REGION_SHIFT+1:REGION_SHIFT]) : sel_q;
   end

   // State, transfer registers and outputs pre-decoded from the next state.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q   <= IDLE;
         addr_q    <= 32'd0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         sel_q     <= 3'b000;
         psel_q    <= 3'b000;
         penable_q <= 1'b0;
         hready_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         if (load_s) begin
            addr_q  <= HADDR;
            write_q <= HWRITE;
         end
         if (state_q == WWAIT) begin
            wdata_q <= HWDATA;
         end
         psel_q    <= ((state_d == SETUP) || (state_d == ACCESS)) ? sel_d : 3'b000;
         penable_q <= (state_d == ACCESS);
         hready_q  <= (state_d == IDLE) || (state_d == ACCESS);
      end
   end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: directed plan steps followed by random
// transfers, checked cycle by cycle against a per-transfer phase model.
`timescale 1ns/1ps
module tb_apb_fsm_controller;
   localparam int DW = 32;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b1;
   logic          valid = 1'b0;
   logic [1:0]    HTRANS = 2'b00;
   logic [31:0]   HADDR = 32'd0;
   logic          HWRITE = 1'b0;
   logic [DW-1:0] HWDATA = '0;
`ifdef PREADY_EN
   logic          PREADY = 1'b1;
`endif
   logic          HREADYout;
   logic [31:0]   PADDR;
   logic [DW-1:0] PWDATA;
   logic          PWRITE;
   logic [2:0]    PSELx;
   logic          PENABLE;

   always #5 HCLK = ~HCLK;

   apb_fsm_controller #(.DATA_WIDTH(DW), .REGION_SHIFT(26)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .valid(valid), .HTRANS(HTRANS), .HADDR(HADDR),
      .HWRITE(HWRITE), .HWDATA(HWDATA),
`ifdef PREADY_EN
      .PREADY(PREADY),
`endif
      .HREADYout(HREADYout), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
      .PSELx(PSELx), .PENABLE(PENABLE)
   );

   // One record per clock cycle: inputs driven in that cycle, outputs expected in it.
   typedef struct packed {
      logic        rst;
      logic        chk;
      logic        v;
      logic [1:0]  tr;
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
      logic        pr;
      logic        e_rdy;
      logic [2:0]  e_sel;
      logic        e_en;
      logic [31:0] e_addr;
      logic        e_wr;
      logic [31:0] e_wd;
   } cyc_t;

   cyc_t        q[$];
   logic [31:0] m_addr, m_wd;
   logic        m_wr;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;

   function automatic logic [2:0] exp_sel(input logic [31:0] a);
      int r;
      r = int'(a[27:26]);
      if (r == 3) return 3'b000;
      return 3'(1 << r);
   endfunction

   function automatic cyc_t idle_rec();
      cyc_t c;
      c.rst = 1'b0; c.chk = 1'b1; c.v = 1'b0; c.tr = 2'($urandom_range(3, 0));
      c.a = $urandom(); c.w = 1'($urandom()); c.d = $urandom(); c.pr = 1'($urandom());
      c.e_rdy = 1'b1; c.e_sel = 3'b000; c.e_en = 1'b0;
      c.e_addr = m_addr; c.e_wr = m_wr; c.e_wd = m_wd;
      return c;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) q.push_back(idle_rec());
   endtask

   task automatic no_start(input logic v, input logic [1:0] tr, input logic [31:0] a);
      cyc_t c;
      c = idle_rec(); c.v = v; c.tr = tr; c.a = a;
      q.push_back(c);
   endtask

   // Present a transfer in the last queued cycle and append its wait/setup/access cycles.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int nw);
      cyc_t c, s;
      logic [2:0] sel;
      c = q.pop_back();
      c.v = 1'b1; c.tr = 2'($urandom_range(3, 2)); c.a = a; c.w = w;
      q.push_back(c);
      sel = exp_sel(a);
      m_addr = a; m_wr = w;
      s = c; s.rst = 1'b0; s.chk = 1'b1; s.pr = 1'($urandom()); s.d = $urandom();
      if (w) begin
         s.d = d; s.e_rdy = 1'b0; s.e_sel = 3'b000; s.e_en = 1'b0;
         s.e_addr = m_addr; s.e_wr = m_wr; s.e_wd = m_wd;
         q.push_back(s);
         m_wd = d; s.d = $urandom();
      end
      s.e_rdy = 1'b0; s.e_sel = sel; s.e_en = 1'b0;
      s.e_addr = m_addr; s.e_wr = m_wr; s.e_wd = m_wd;
      q.push_back(s);
      for (int k = 0; k <= nw; k++) begin
         s = idle_rec();
         s.pr = (k == nw); s.e_rdy = (k == nw); s.e_sel = sel; s.e_en = 1'b1;
         q.push_back(s);
      end
   endtask

   task automatic do_reset(input int n);
      cyc_t c;
      c = q.pop_back(); c.rst = 1'b1; c.v = 1'b0;
      q.push_back(c);
      m_addr = 32'd0; m_wd = 32'd0; m_wr = 1'b0;
      for (int i = 1; i < n; i++) begin
         c = idle_rec(); c.rst = 1'b1;
         q.push_back(c);
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      cyc_t c;
      logic [31:0] ra;
      int nw;
      m_addr = 32'd0; m_wd = 32'd0; m_wr = 1'b0;
      c = idle_rec(); c.rst = 1'b1; c.chk = 1'b0; q.push_back(c);
      c = idle_rec(); c.rst = 1'b1; q.push_back(c);
      idle(1);
      no_start(1'b1, 2'b01, 32'h8400_0000);
      no_start(1'b1, 2'b00, 32'h8400_0000);
      no_start(1'b0, 2'b10, 32'h9000_0000);
      idle(1);
      xfer(32'h8400_0010, 1'b0, 32'd0, 0);
      idle(1);
      xfer(32'h8800_0004, 1'b1, 32'hDEAD_BEEF, 0);
      idle(1);
      xfer(32'h8000_0100, 1'b0, 32'd0, 0);
      xfer(32'h8000_0200, 1'b0, 32'd0, 0);
      xfer(32'h8400_0300, 1'b1, 32'h1234_5678, 0);
      xfer(32'h8800_0400, 1'b1, 32'hA5A5_5A5A, 0);
      idle(2);
      xfer(32'h8C00_0040, 1'b1, 32'h0BAD_F00D, 0);
      idle(1);
      xfer(32'h8000_0300, 1'b0, 32'd0, 0);
      do_reset(2);
      idle(2);
`ifdef PREADY_EN
      xfer(32'h8400_0020, 1'b0, 32'd0, 3);
      idle(1);
`endif
      for (int i = 0; i < 60; i++) begin
         idle($urandom_range(2, 0));
         ra = 32'h8000_0000 | (32'($urandom_range(7, 0) == 0 ? 3 : $urandom_range(2, 0)) << 26)
              | ($urandom() & 32'h03FF_FFFC);
`ifdef PREADY_EN
         nw = $urandom_range(2, 0);
`else
         nw = 0;
`endif
         xfer(ra, 1'($urandom()), $urandom(), nw);
      end
      idle(2);

      foreach (q[i]) begin
         @(negedge HCLK);
         c = q[i];
         HRESET = c.rst; valid = c.v; HTRANS = c.tr; HADDR = c.a; HWRITE = c.w; HWDATA = c.d;
`ifdef PREADY_EN
         PREADY = c.pr;
`endif
         #1;
         cyc = i;
         if (c.chk) begin
            check("HREADYout", {31'd0, HREADYout}, {31'd0, c.e_rdy});
            check("PSELx",     {29'd0, PSELx},     {29'd0, c.e_sel});
            check("PENABLE",   {31'd0, PENABLE},   {31'd0, c.e_en});
            check("PADDR",     PADDR,              c.e_addr);
            check("PWRITE",    {31'd0, PWRITE},    {31'd0, c.e_wr});
            check("PWDATA",    PWDATA,             c.e_wd);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
